// File: rtl/shiftreg_reader.sv
// 74HC165 parallel-in/serial-out reader: pulses SH/LD, clocks WIDTH bits in on QH,
// then presents them as a parallel word with a one-cycle o_Valid strobe.
module shiftreg_reader #(
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_Start,
  input  logic             i_QH,
  output logic             o_Ready,
  output logic             o_Valid,
  output logic [WIDTH-1:0] o_Data,
  output logic             o_SH_LD,
  output logic             o_CLK
);

  localparam int BW = $clog2(WIDTH) + 1;
  localparam int DW = $clog2(CLK_DIV) + 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_SETTLE,
    S_SAMPLE,
    S_CLK_HI,
    S_CLK_LO,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic [DW-1:0]    divcnt_q, divcnt_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             ready_q, ready_d;
  logic             valid_q, valid_d;
  logic             sh_ld_q, sh_ld_d;
  logic             clk_q, clk_d;

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    divcnt_d = divcnt_q;
    shreg_d  = shreg_q;
    data_d   = data_q;
    ready_d  = ready_q;
    valid_d  = 1'b0;
    sh_ld_d  = sh_ld_q;
    clk_d    = clk_q;

    case (state_q)
      S_IDLE: begin
        if (i_Start && ready_q) begin
          state_d  = S_LOAD;
          sh_ld_d  = 1'b0;
          ready_d  = 1'b0;
          bitcnt_d = '0;
          divcnt_d = '0;
        end
      end
      S_LOAD: begin
        if (divcnt_q == DIV_LAST) begin
          divcnt_d = '0;
          sh_ld_d  = 1'b1;
          state_d  = S_SETTLE;
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      S_SETTLE: begin
        if (divcnt_q == DIV_LAST) begin
          divcnt_d = '0;
          state_d  = S_SAMPLE;
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      // The last bit is sampled without a following CLK pulse, giving WIDTH-1 pulses total.
      S_SAMPLE: begin
        shreg_d = {shreg_q[WIDTH-2:0], i_QH};
        if (bitcnt_q == BIT_LAST) begin
          state_d = S_DONE;
        end else begin
          bitcnt_d = bitcnt_q + BW'(1);
          clk_d    = 1'b1;
          state_d  = S_CLK_HI;
        end
      end
      S_CLK_HI: begin
        if (divcnt_q == DIV_LAST) begin
          divcnt_d = '0;
          clk_d    = 1'b0;
          state_d  = S_CLK_LO;
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      S_CLK_LO: begin
        if (divcnt_q == DIV_LAST) begin
          divcnt_d = '0;
          state_d  = S_SAMPLE;
        end else begin
          divcnt_d = divcnt_q + DW'(1);
        end
      end
      S_DONE: begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        ready_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      divcnt_q <= '0;
      shreg_q  <= '0;
      data_q   <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
      sh_ld_q  <= 1'b1;
      clk_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      divcnt_q <= divcnt_d;
      shreg_q  <= shreg_d;
      data_q   <= data_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      sh_ld_q  <= sh_ld_d;
      clk_q    <= clk_d;
    end
  end

  assign o_Ready = ready_q;
  assign o_Valid = valid_q;
  assign o_Data  = data_q;
  assign o_SH_LD = sh_ld_q;
  assign o_CLK   = clk_q;

endmodule

// File: tb/tb_shiftreg_reader.sv
// Bench for shiftreg_reader: behavioural 74HC165 chips feed two DUT configurations
// (8-bit / CLK_DIV=2 and 16-bit chained / CLK_DIV=1), checked against pin values and timing rules.
module tb_shiftreg_reader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 8-bit instance
  logic        start8 = 1'b0;
  logic        qh8, ready8, valid8, ld8, ck8;
  logic [7:0]  data8;
  logic [7:0]  pins8 = 8'h00;
  logic [7:0]  chip8 = 8'h00;
  logic        ck8Prev = 1'b0;

  // 16-bit instance with two chained chips
  logic        start16 = 1'b0;
  logic        qh16, ready16, valid16, ld16, ck16;
  logic [15:0] data16;
  logic [7:0]  pinsHi = 8'h00, pinsLo = 8'h00;
  logic [7:0]  chipHi = 8'h00, chipLo = 8'h00;
  logic        ck16Prev = 1'b0;

  int checks = 0;
  int errors = 0;

  shiftreg_reader #(.WIDTH(8), .CLK_DIV(2)) dut8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_Start(start8), .i_QH(qh8),
    .o_Ready(ready8), .o_Valid(valid8), .o_Data(data8), .o_SH_LD(ld8), .o_CLK(ck8)
  );

  shiftreg_reader #(.WIDTH(16), .CLK_DIV(1)) dut16 (
    .i_clk(clk), .i_rst_n(rst_n), .i_Start(start16), .i_QH(qh16),
    .o_Ready(ready16), .o_Valid(valid16), .o_Data(data16), .o_SH_LD(ld16), .o_CLK(ck16)
  );

  // 74HC165: transparent parallel load while SH/LD is low, shift on CLK rise otherwise.
  always @(ck8 or ld8 or pins8) begin
    if (!ld8) chip8 = pins8;
    else if (ck8 && !ck8Prev) chip8 = {chip8[6:0], 1'b0};
    ck8Prev = ck8;
  end
  assign qh8 = ld8 ? chip8[7] : pins8[7];

  always @(ck16 or ld16 or pinsHi or pinsLo) begin
    if (!ld16) begin
      chipHi = pinsHi;
      chipLo = pinsLo;
    end else if (ck16 && !ck16Prev) begin
      chipHi = {chipHi[6:0], chipLo[7]};
      chipLo = {chipLo[6:0], 1'b0};
    end
    ck16Prev = ck16;
  end
  assign qh16 = ld16 ? chipHi[7] : pinsHi[7];

  // Free-running pin activity monitors; tasks take differences across a read.
  int ldPulses8 = 0, ldLowCyc8 = 0, ckRises8 = 0;
  int ldPulses16 = 0, ldLowCyc16 = 0, ckRises16 = 0;
  always @(negedge ld8)  ldPulses8  <= ldPulses8 + 1;
  always @(posedge ck8)  ckRises8   <= ckRises8 + 1;
  always @(negedge ld16) ldPulses16 <= ldPulses16 + 1;
  always @(posedge ck16) ckRises16  <= ckRises16 + 1;
  always @(posedge clk) begin
    if (!ld8)  ldLowCyc8  <= ldLowCyc8 + 1;
    if (!ld16) ldLowCyc16 <= ldLowCyc16 + 1;
  end

  function automatic int expLatency(input int w, input int cd);
    return 2 * cd + w + (w - 1) * 2 * cd + 1;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus8(input logic [7:0] pinVal, input string tag);
    int p0, l0, c0, cyc;
    @(negedge clk);
    pins8 = pinVal;
    checkOutput({tag, "_ready_before"}, 32'(ready8), 32'd1);
    p0 = ldPulses8; l0 = ldLowCyc8; c0 = ckRises8;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (!valid8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(expLatency(8, 2)));
    checkOutput({tag, "_data"}, 32'(data8), 32'(pinVal));
    checkOutput({tag, "_ready_at_valid"}, 32'(ready8), 32'd1);
    checkOutput({tag, "_ld_pulses"}, 32'(ldPulses8 - p0), 32'd1);
    checkOutput({tag, "_ld_low_cycles"}, 32'(ldLowCyc8 - l0), 32'd2);
    checkOutput({tag, "_clk_rises"}, 32'(ckRises8 - c0), 32'd7);
    @(negedge clk);
    checkOutput({tag, "_valid_one_cycle"}, 32'(valid8), 32'd0);
    checkOutput({tag, "_data_hold"}, 32'(data8), 32'(pinVal));
  endtask

  task automatic applyStimulus16(input logic [15:0] pinVal, input string tag);
    int p0, l0, c0, cyc, extraValid, notReady;
    @(negedge clk);
    pinsHi = pinVal[15:8];
    pinsLo = pinVal[7:0];
    checkOutput({tag, "_ready_before"}, 32'(ready16), 32'd1);
    p0 = ldPulses16; l0 = ldLowCyc16; c0 = ckRises16;
    start16 = 1'b1;
    @(negedge clk);
    start16 = 1'b0;
    cyc = 0;
    while (!valid16 && cyc < 300) begin
      @(negedge clk);
      cyc++;
      start16 = (cyc == 5 || cyc == 20);
    end
    start16 = 1'b0;
    checkOutput({tag, "_latency"}, 32'(cyc), 32'(expLatency(16, 1)));
    checkOutput({tag, "_data"}, 32'(data16), 32'(pinVal));
    checkOutput({tag, "_ld_pulses"}, 32'(ldPulses16 - p0), 32'd1);
    checkOutput({tag, "_ld_low_cycles"}, 32'(ldLowCyc16 - l0), 32'd1);
    checkOutput({tag, "_clk_rises"}, 32'(ckRises16 - c0), 32'd15);
    extraValid = 0;
    notReady = 0;
    repeat (30) begin
      @(negedge clk);
      if (valid16) extraValid++;
      if (!ready16) notReady++;
    end
    checkOutput({tag, "_busy_starts_ignored"}, 32'(extraValid), 32'd0);
    checkOutput({tag, "_stays_ready"}, 32'(notReady), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog timeout got=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, validCount, c0;
    logic [7:0] rnd8;

    // Reset values
    repeat (3) @(negedge clk);
    checkOutput("rst_ready", 32'(ready8), 32'd1);
    checkOutput("rst_valid", 32'(valid8), 32'd0);
    checkOutput("rst_data", 32'(data8), 32'd0);
    checkOutput("rst_sh_ld", 32'(ld8), 32'd1);
    checkOutput("rst_clk", 32'(ck8), 32'd0);
    checkOutput("rst16_ready", 32'(ready16), 32'd1);
    checkOutput("rst16_data", 32'(data16), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Single read and bit order
    applyStimulus8(8'hA5, "read_a5");
    applyStimulus8(8'h80, "order_80");
    applyStimulus8(8'h01, "order_01");
    applyStimulus8(8'h00, "order_00");
    applyStimulus8(8'hFF, "order_ff");
    for (int i = 0; i < 6; i++) begin
      rnd8 = 8'($urandom);
      applyStimulus8(rnd8, $sformatf("rand8_%0d", i));
    end

    // Start held high: back-to-back reads, pin change mid-read not seen
    @(negedge clk);
    pins8 = 8'h3C;
    start8 = 1'b1;
    @(negedge clk);
    cyc = 0;
    while (!valid8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("b2b_first_latency", 32'(cyc), 32'(expLatency(8, 2)));
    checkOutput("b2b_first_data", 32'(data8), 32'h3C);
    checkOutput("b2b_ready_with_valid", 32'(ready8), 32'd1);
    pins8 = 8'hC3;
    @(negedge clk);
    checkOutput("b2b_ready_one_cycle", 32'(ready8), 32'd0);
    cyc = 0;
    while (!valid8 && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == 10) begin
        pins8 = 8'hFF;
        start8 = 1'b0;
      end
    end
    checkOutput("b2b_period", 32'(cyc + 1), 32'(expLatency(8, 2) + 1));
    checkOutput("b2b_second_data", 32'(data8), 32'hC3);
    applyStimulus8(8'hFF, "b2b_next_sees_change");

    // Reset during CLK_HI of bit 3 aborts the read
    @(negedge clk);
    pins8 = 8'h96;
    c0 = ckRises8;
    start8 = 1'b1;
    @(negedge clk);
    start8 = 1'b0;
    cyc = 0;
    while (!((ckRises8 - c0) == 3 && ck8) && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    checkOutput("abort_reached_clk_hi", 32'(ck8), 32'd1);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_clk_low", 32'(ck8), 32'd0);
    checkOutput("abort_sh_ld_high", 32'(ld8), 32'd1);
    checkOutput("abort_ready", 32'(ready8), 32'd1);
    checkOutput("abort_data_cleared", 32'(data8), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    validCount = 0;
    repeat (80) begin
      @(negedge clk);
      if (valid8) validCount++;
    end
    checkOutput("abort_no_valid", 32'(validCount), 32'd0);
    applyStimulus8(8'h5A, "after_abort_5a");

    // Chained 16-bit configuration
    applyStimulus16(16'h1234, "chain_1234");
    for (int i = 0; i < 3; i++) begin
      applyStimulus16(16'($urandom), $sformatf("rand16_%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
